// File: rtl/xup_tri_bus_drive_ctrl.sv
// Drive sequencer for a vector tri-state buffer on a shared bus: stream beats in,
// registered data and active-low enable out, with turnaround guard cycles around each window.
module xup_tri_bus_drive_ctrl #(
    parameter int SIZE  = 8,
    parameter int GUARD = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [SIZE-1:0] s_data,
    input  logic            s_last,
    input  logic            bus_grant,
    output logic [SIZE-1:0] drv_data,
    output logic            drv_en_n,
    output logic            busy,
    output logic            aborted
);

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, RELEASE} state_t;

    localparam logic [3:0] G = 4'(GUARD);

    state_t     state;
    logic [3:0] gcnt;
    logic       accept;

    assign s_ready = (state == DRIVE) && bus_grant;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gcnt     <= 4'd0;
            drv_data <= '0;
            drv_en_n <= 1'b1;
            busy     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    drv_en_n <= 1'b1;
                    if (s_valid && bus_grant) begin
                        busy <= 1'b1;
                        if (G == 4'd0) begin
                            state <= DRIVE;
                        end else begin
                            state <= SETUP;
                            gcnt  <= G - 4'd1;
                        end
                    end
                end
                SETUP: begin
                    // Losing grant before any beat is driven is not an abort.
                    if (!bus_grant) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gcnt == 4'd0) begin
                        state <= DRIVE;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                DRIVE: begin
                    if (!bus_grant) begin
                        drv_en_n <= 1'b1;
                        aborted  <= 1'b1;
                        if (G == 4'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RELEASE;
                            gcnt  <= G - 4'd1;
                        end
                    end else if (accept) begin
                        drv_data <= s_data;
                        drv_en_n <= 1'b0;
                        // One extra count so the last beat is presented before the guard.
                        if (s_last) begin
                            state <= RELEASE;
                            gcnt  <= G;
                        end
                    end
                end
                RELEASE: begin
                    drv_en_n <= 1'b1;
                    if (gcnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    drv_en_n <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
